// File: rtl/elastic_operator_pkg.sv
// Shared definitions for the elastic operator: op codes, op-string decoding
// and the legal parameter ranges.
package elastic_operator_pkg;

  typedef enum logic [3:0] {
    OP_REG,
    OP_IN,
    OP_OUT,
    OP_ADDI,
    OP_SUBI,
    OP_MULI,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_BAD
  } op_e;

  localparam int INPUT_SIZE_MIN  = 1;
  localparam int INPUT_SIZE_MAX  = 3;
  localparam int OUTPUT_SIZE_MIN = 1;
  localparam int OUTPUT_SIZE_MAX = 8;
  localparam int DEPTH_MIN       = 2;
  localparam int DEPTH_MAX       = 64;

  function automatic op_e op_from_string(input string s);
    op_e op;
    op = OP_BAD;
    if (s == "reg")       op = OP_REG;
    else if (s == "in")   op = OP_IN;
    else if (s == "out")  op = OP_OUT;
    else if (s == "addi") op = OP_ADDI;
    else if (s == "subi") op = OP_SUBI;
    else if (s == "muli") op = OP_MULI;
    else if (s == "add")  op = OP_ADD;
    else if (s == "sub")  op = OP_SUB;
    else if (s == "mul")  op = OP_MUL;
    return op;
  endfunction

  // Unary ops take exactly one operand channel, binary/ternary ops two or three.
  function automatic bit op_legal(input op_e op, input int input_size);
    bit unary;
    bit nary;
    unary = (op == OP_REG) || (op == OP_IN) || (op == OP_OUT) ||
            (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MULI);
    nary  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    return (unary && input_size == 1) ||
           (nary && input_size >= 2 && input_size <= INPUT_SIZE_MAX);
  endfunction

endpackage

// File: rtl/elastic_operator_alu.sv
// Combinational datapath of the elastic operator; all arithmetic wraps
// modulo 2^DATA_WIDTH.
module elastic_operator_alu
  import elastic_operator_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    INPUT_SIZE = 2,
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE  = '0
) (
  input  op_e                              op,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] operands,
  output logic [DATA_WIDTH-1:0]            result
);

  always_comb begin
    result = operands[DATA_WIDTH-1:0];
    case (op)
      OP_ADDI: result = result + IMMEDIATE;
      OP_SUBI: result = result - IMMEDIATE;
      OP_MULI: result = result * IMMEDIATE;
      OP_ADD: begin
        for (int i = 1; i < INPUT_SIZE; i++)
          result = result + operands[i*DATA_WIDTH +: DATA_WIDTH];
      end
      OP_SUB: begin
        for (int i = 1; i < INPUT_SIZE; i++)
          result = result - operands[i*DATA_WIDTH +: DATA_WIDTH];
      end
      OP_MUL: begin
        for (int i = 1; i < INPUT_SIZE; i++)
          result = result * operands[i*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/elastic_operator.sv
// Elastic operator: collects one operand per input channel, computes a result
// and broadcasts it to independent consumers through a shared FIFO.
module elastic_operator
  import elastic_operator_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INPUT_SIZE  = 2,
  parameter int                    OUTPUT_SIZE = 3,
  parameter int                    DEPTH       = 4,
  parameter string                 OP          = "add",
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
  output logic [$clog2(DEPTH):0]            occupancy
);

  localparam int  AW      = $clog2(DEPTH);
  localparam int  PW      = AW + 1;
  localparam op_e OP_CODE = op_from_string(OP);

  if (!op_legal(OP_CODE, INPUT_SIZE) ||
      OUTPUT_SIZE < OUTPUT_SIZE_MIN || OUTPUT_SIZE > OUTPUT_SIZE_MAX ||
      DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("elastic_operator: illegal parameter combination");
  end

  logic [INPUT_SIZE-1:0]            has;
  logic [DATA_WIDTH*INPUT_SIZE-1:0] opnd;
  logic [DATA_WIDTH-1:0]            result;
  logic [DATA_WIDTH-1:0]            mem [DEPTH];
  logic [PW-1:0]                    wptr;
  logic [PW-1:0]                    rptr [OUTPUT_SIZE];
  logic [PW-1:0]                    occ;
  logic                             full;
  logic                             write;

  elastic_operator_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .INPUT_SIZE (INPUT_SIZE),
    .IMMEDIATE  (IMMEDIATE)
  ) u_alu (
    .op       (OP_CODE),
    .operands (opnd),
    .result   (result)
  );

  // Occupancy is measured against the slowest consumer; pointers wrap naturally.
  always_comb begin
    occ = '0;
    for (int k = 0; k < OUTPUT_SIZE; k++) begin
      if ((wptr - rptr[k]) > occ) occ = wptr - rptr[k];
    end
  end

  assign full      = (occ == PW'(DEPTH));
  assign write     = (&has) && !full;
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      has   <= '0;
      req_l <= '0;
      opnd  <= '0;
      wptr  <= '0;
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        // An ack on a channel that already holds its operand is dropped.
        if (ack_l[i] && !has[i]) opnd[i*DATA_WIDTH +: DATA_WIDTH] <= din[i*DATA_WIDTH +: DATA_WIDTH];
        if (write)         has[i] <= 1'b0;
        else if (ack_l[i]) has[i] <= 1'b1;
        req_l[i] <= !has[i] && !ack_l[i];
      end
      if (write) wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write && !rst) mem[wptr[AW-1:0]] <= result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r <= '0;
      dout  <= '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) rptr[k] <= '0;
    end else begin
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
        ack_r[k] <= 1'b0;
        if (req_r[k] && !ack_r[k] && (rptr[k] != wptr)) begin
          ack_r[k]                          <= 1'b1;
          dout[k*DATA_WIDTH +: DATA_WIDTH]  <= mem[rptr[k][AW-1:0]];
          rptr[k]                           <= rptr[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_elastic_operator.sv
// Randomized bench for elastic_operator: a queue-based model of the operand
// streams predicts every broadcast result; two extra instances cover sub/muli.
module tb_elastic_operator;
  localparam int DW = 32;
  localparam int NI = 2;
  localparam int NO = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]    req_l, ack_l;
  logic [NI*DW-1:0] din;
  logic [NO-1:0]    req_r, ack_r;
  logic [NO*DW-1:0] dout;
  logic [2:0]       occupancy;

  elastic_operator #(
    .DATA_WIDTH(DW), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO), .DEPTH(DEPTH), .OP("add")
  ) dut (
    .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
    .req_r(req_r), .ack_r(ack_r), .dout(dout), .occupancy(occupancy)
  );

  logic [1:0]  s_req_l, s_ack_l;
  logic [63:0] s_din;
  logic        s_req_r, s_ack_r;
  logic [31:0] s_dout;
  logic [1:0]  s_occ;

  elastic_operator #(
    .DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2), .OP("sub")
  ) dut_sub (
    .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din),
    .req_r(s_req_r), .ack_r(s_ack_r), .dout(s_dout), .occupancy(s_occ)
  );

  logic        m_req_l, m_ack_l;
  logic [31:0] m_din;
  logic        m_req_r, m_ack_r;
  logic [31:0] m_dout;
  logic [1:0]  m_occ;

  elastic_operator #(
    .DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2), .OP("muli"), .IMMEDIATE(32'd3)
  ) dut_muli (
    .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din),
    .req_r(m_req_r), .ack_r(m_ack_r), .dout(m_dout), .occupancy(m_occ)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the j-th result is the sum of the j-th accepted operand of each channel.
  logic [DW-1:0] ops [NI][$];
  int            rd_cnt [NO];
  int            cmode [NO];   // 0 always ready, 1 held low, 2 every 3rd cycle, 3 random
  int            sent [NI];
  int            limit [NI];
  bit            prod_en;
  bit            prod_rand;
  int            cyc;
  logic [NO-1:0] prev_ack;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_result(input int j);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < NI; i++) s = s + ops[i][j];
    return s;
  endfunction

  // One clock: score the outputs at the falling edge, then drive the next inputs.
  task automatic cycle();
    logic [DW-1:0] val;
    @(negedge clk);
    cyc++;
    if (rst) begin
      for (int k = 0; k < NO; k++) rd_cnt[k] = 0;
      prev_ack = '0;
    end else begin
      for (int k = 0; k < NO; k++) begin
        if (ack_r[k]) begin
          check($sformatf("ack_pulse%0d", k), prev_ack[k], 1'b0);
          if (rd_cnt[k] < ops[0].size() && rd_cnt[k] < ops[1].size())
            check($sformatf("dout%0d[%0d]", k, rd_cnt[k]), dout[k*DW +: DW], exp_result(rd_cnt[k]));
          else
            check($sformatf("unexpected_ack%0d", k), ack_r[k], 1'b0);
          rd_cnt[k]++;
        end
      end
      prev_ack = ack_r;
    end
    for (int k = 0; k < NO; k++) begin
      case (cmode[k])
        0:       req_r[k] = 1'b1;
        1:       req_r[k] = 1'b0;
        2:       req_r[k] = (cyc % 3 == 0);
        default: req_r[k] = 1'($urandom_range(0, 1));
      endcase
    end
    for (int i = 0; i < NI; i++) begin
      if (ack_l[i]) begin
        ack_l[i] = 1'b0;
      end else if (prod_en && req_l[i] && sent[i] < limit[i] && $urandom_range(0, 3) != 0) begin
        val = prod_rand ? DW'($urandom) : DW'(sent[i]);
        din[i*DW +: DW] = val;
        ack_l[i] = 1'b1;
        ops[i].push_back(val);
        sent[i]++;
      end
    end
  endtask

  task automatic do_reset();
    prod_en = 1'b0;
    ack_l   = '0;
    rst     = 1'b1;
    cycle();
    check("rst_req_l", req_l, 0);
    check("rst_ack_r", ack_r, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_dout", dout, 0);
    for (int i = 0; i < NI; i++) begin
      ops[i].delete();
      sent[i] = 0;
    end
    rst = 1'b0;
    cycle();
    check("req_l_after_rst", req_l, 2'b11);
  endtask

  initial begin
    int t;
    logic [31:0] a, b, e;
    ack_l = '0; din = '0; req_r = '0;
    s_ack_l = '0; s_din = '0; s_req_r = 1'b0;
    m_ack_l = 1'b0; m_din = '0; m_req_r = 1'b0;
    prod_en = 1'b0; prod_rand = 1'b0; cyc = 0; prev_ack = '0;
    for (int k = 0; k < NO; k++) begin cmode[k] = 0; rd_cnt[k] = 0; end
    for (int i = 0; i < NI; i++) begin sent[i] = 0; limit[i] = 0; end
    cycle();
    do_reset();

    // 5 + 7: ack_r rises two edges after the edge that samples the last ack_l
    din[31:0] = 32'd5; ack_l[0] = 1'b1; ops[0].push_back(32'd5);
    cycle();
    din[63:32] = 32'd7; ack_l[1] = 1'b1; ops[1].push_back(32'd7);
    cycle();
    check("lat_edge0_ack_r", ack_r, 0);
    cycle();
    check("lat_edge1_ack_r", ack_r, 0);
    check("lat_edge1_occupancy", occupancy, 1);
    cycle();
    check("lat_edge2_ack_r", ack_r, 3'b111);
    for (int k = 0; k < NO; k++) check($sformatf("add_5_7_c%0d", k), dout[k*DW +: DW], 32'd12);

    // spurious ack on a channel that already holds its operand
    repeat (3) cycle();
    din[31:0] = 32'h1111; ack_l[0] = 1'b1; ops[0].push_back(32'h1111);
    cycle();
    cycle();
    check("spurious_req_l0_low", req_l[0], 1'b0);
    din[31:0] = 32'hDEAD; ack_l[0] = 1'b1;
    cycle();
    din[63:32] = 32'h2222; ack_l[1] = 1'b1; ops[1].push_back(32'h2222);
    t = 0;
    while (rd_cnt[2] < 2 && t < 20) begin cycle(); t++; end
    check("spurious_read_count", rd_cnt[2], 2);
    check("spurious_ignored", dout[31:0], 32'h3333);

    // consumer 2 stalled: four results buffer up, then producers are held off
    cmode[2] = 1;
    for (int i = 0; i < NI; i++) begin sent[i] = 0; limit[i] = 1 << 30; end
    prod_rand = 1'b0;
    prod_en = 1'b1;
    repeat (60) cycle();
    check("full_occupancy", occupancy, 4);
    check("full_req_l", req_l, 0);
    check("full_fast_reads", rd_cnt[0], 6);
    check("full_stalled_reads", rd_cnt[2], 2);
    cmode[2] = 0;
    repeat (80) cycle();
    check("flow_resumes", rd_cnt[2] >= 10, 1'b1);

    // reset with three buffered results and one operand held
    do_reset();
    for (int k = 0; k < NO; k++) cmode[k] = 1;
    limit[0] = 4; limit[1] = 3;
    prod_rand = 1'b1;
    prod_en = 1'b1;
    t = 0;
    while (!(occupancy == 3 && sent[0] == 4) && t < 200) begin cycle(); t++; end
    repeat (3) cycle();
    check("pre_rst_occupancy", occupancy, 3);
    do_reset();
    for (int k = 0; k < NO; k++) cmode[k] = 0;
    limit[0] = 1 << 30; limit[1] = 1 << 30;
    prod_en = 1'b1;
    repeat (50) cycle();
    check("post_rst_flow", rd_cnt[0] > 0, 1'b1);

    // 1000 random items to consumers with different pacing
    do_reset();
    cmode[0] = 0; cmode[1] = 2; cmode[2] = 3;
    limit[0] = 1000; limit[1] = 1000;
    prod_rand = 1'b1;
    prod_en = 1'b1;
    t = 0;
    while ((rd_cnt[0] < 1000 || rd_cnt[1] < 1000 || rd_cnt[2] < 1000) && t < 20000) begin
      cycle(); t++;
    end
    repeat (10) cycle();
    for (int k = 0; k < NO; k++) check($sformatf("stream_count%0d", k), rd_cnt[k], 1000);
    check("stream_drained", occupancy, 0);
    prod_en = 1'b0;

    // sub instance: ch0 - ch1 modulo 2^32
    s_req_r = 1'b1;
    for (int n = 0; n < 4; n++) begin
      a = (n == 0) ? 32'd3 : $urandom;
      b = (n == 0) ? 32'd5 : $urandom;
      e = a - b;
      t = 0;
      while (s_req_l != 2'b11 && t < 20) begin cycle(); t++; end
      check("sub_req_l", s_req_l, 2'b11);
      s_din = {b, a}; s_ack_l = 2'b11;
      cycle();
      s_ack_l = '0;
      t = 0;
      while (!s_ack_r && t < 20) begin cycle(); t++; end
      check("sub_ack_r", s_ack_r, 1'b1);
      check($sformatf("sub_%0d", n), s_dout, e);
    end

    // muli instance: low 32 bits of ch0 * 3
    m_req_r = 1'b1;
    for (int n = 0; n < 4; n++) begin
      a = (n == 0) ? 32'h8000_0001 : $urandom;
      e = a * 32'd3;
      t = 0;
      while (!m_req_l && t < 20) begin cycle(); t++; end
      check("muli_req_l", m_req_l, 1'b1);
      m_din = a; m_ack_l = 1'b1;
      cycle();
      m_ack_l = 1'b0;
      t = 0;
      while (!m_ack_r && t < 20) begin cycle(); t++; end
      check("muli_ack_r", m_ack_r, 1'b1);
      check($sformatf("muli_%0d", n), m_dout, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
